// File: rtl/prbs_test_sequencer.sv
// Purpose: walks a queue of (pattern, repeat) entries through the PRBS datapath, judging each by pattern_correct.
// Latency: start to first prbs_valid is 2 cycles; each entry takes 1 load + VALID_CYCLES drive + up to TIMEOUT wait cycles.
// Backpressure: none; a push into a full config FIFO is dropped and flagged with a one-cycle cfg_overflow pulse.
module prbs_test_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int REP_WIDTH    = 8,
  parameter int DEPTH        = 4,
  parameter int VALID_CYCLES = 5,
  parameter int TIMEOUT      = 64,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_push,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic [REP_WIDTH-1:0]  cfg_n,
  output logic                  cfg_full,
  output logic                  cfg_overflow,
  output logic [DATA_WIDTH-1:0] prbs_in,
  output logic [REP_WIDTH-1:0]  prbs_n,
  output logic                  prbs_valid,
  input  logic                  pattern_correct,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (VALID_CYCLES > TIMEOUT) ? VALID_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_WAIT, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] prbs_in_q, prbs_in_d;
  logic [REP_WIDTH-1:0]  prbs_n_q, prbs_n_d;
  logic                  prbs_valid_q, prbs_valid_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic                  hit_q, hit_d;
  logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
  logic                  overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] fifo_data_mem [DEPTH];
  logic [REP_WIDTH-1:0]  fifo_n_mem    [DEPTH];

  logic                  fifo_empty;
  logic                  pop;
  logic                  push_ok;
  logic [DATA_WIDTH-1:0] head_data;
  logic [REP_WIDTH-1:0]  head_n;
  logic                  drive_last;
  logic                  wait_last;
  logic                  hit_now;

  // Shared decode: FIFO handshakes and per-entry timing conditions
  always_comb begin
    fifo_empty = (count_q == '0);
    cfg_full   = (count_q == (AW+1)'(DEPTH));
    pop        = (state_q == S_LOAD) && !fifo_empty && !abort;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    push_ok    = cfg_push && (!cfg_full || pop) && !abort;
    head_data  = fifo_data_mem[rd_ptr_q];
    head_n     = fifo_n_mem[rd_ptr_q];
    drive_last = (cyc_q == CW'(VALID_CYCLES - 1));
    wait_last  = (cyc_q == CW'(TIMEOUT - 1));
    hit_now    = hit_q || pattern_correct;
  end

  // FIFO storage; contents need no reset because pointers and count gate every read
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_data_mem[wr_ptr_q] <= cfg_data;
      fifo_n_mem[wr_ptr_q]    <= cfg_n;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_LOAD;
        S_LOAD: begin
          if (fifo_empty)          state_d = S_FIN;
          else if (head_n != '0)   state_d = S_DRIVE;
        end
        S_DRIVE: if (drive_last) state_d = S_WAIT;
        S_WAIT:  if (hit_now || wait_last) state_d = S_LOAD;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: FIFO pointers, PRBS drive, entry timer, hit flag, counters
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    prbs_in_d    = prbs_in_q;
    prbs_n_d     = prbs_n_q;
    prbs_valid_d = prbs_valid_q;
    cyc_d        = cyc_q;
    hit_d        = hit_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    overflow_d   = cfg_push && cfg_full && !pop;

    if (abort) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      prbs_valid_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

      case (state_q)
        S_IDLE: begin
          if (start) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
          end
        end
        S_LOAD: begin
          if (pop) begin
            prbs_in_d = head_data;
            prbs_n_d  = head_n;
            if (head_n == '0) begin
              // A zero repeat count cannot be exercised, so it is scored as a failure
              if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
            end else begin
              prbs_valid_d = 1'b1;
              cyc_d        = '0;
              hit_d        = 1'b0;
            end
          end
        end
        S_DRIVE: begin
          // Hits are remembered but never cut the drive window short
          hit_d = hit_now;
          if (drive_last) begin
            prbs_valid_d = 1'b0;
            cyc_d        = '0;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (hit_now) begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
          end else if (wait_last) begin
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      prbs_in_q    <= '0;
      prbs_n_q     <= '0;
      prbs_valid_q <= 1'b0;
      cyc_q        <= '0;
      hit_q        <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      prbs_in_q    <= prbs_in_d;
      prbs_n_q     <= prbs_n_d;
      prbs_valid_q <= prbs_valid_d;
      cyc_q        <= cyc_d;
      hit_q        <= hit_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // Outputs: status decoded from state, everything else straight from flops
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_FIN);
    prbs_in      = prbs_in_q;
    prbs_n       = prbs_n_q;
    prbs_valid   = prbs_valid_q;
    pass_cnt     = pass_cnt_q;
    fail_cnt     = fail_cnt_q;
    cfg_overflow = overflow_q;
  end

endmodule

// File: doc/prbs_test_sequencer.md
Name: prbs_test_sequencer

Overview:
Controller that sequences the PRBS datapath (PRBS_TOP) through a queue of test patterns without bench intervention. Software or a bench pushes (pattern, repeat-count) pairs into an internal FIFO. On start, the block drives IN/N/Valid for each entry in turn, watches pattern_correct within a bounded window, and accumulates pass/fail counts. It sits directly above PRBS_TOP and owns its IN, N and Valid inputs.

Parameters:
DATA_WIDTH, 32, width of pattern word (matches PRBS IN)
REP_WIDTH, 8, width of repeat count (matches PRBS N)
DEPTH, 4, config FIFO entries (power of 2, >=2)
VALID_CYCLES, 5, cycles prbs_valid is held high per entry (>=1)
TIMEOUT, 64, max cycles to wait for pattern_correct after Valid drops (>=1)
CNT_WIDTH, 8, width of pass/fail counters

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
start  in  1  begin run; accepted only in IDLE
abort  in  1  stop run; flush FIFO; return to IDLE
cfg_push  in  1  write cfg_data/cfg_n into FIFO
cfg_data  in  DATA_WIDTH  pattern word to queue
cfg_n  in  REP_WIDTH  repeat count to queue
cfg_full  out  1  FIFO full (combinational from count)
cfg_overflow  out  1  one-cycle pulse: push dropped because full
prbs_in  out  DATA_WIDTH  to PRBS IN, registered
prbs_n  out  REP_WIDTH  to PRBS N, registered
prbs_valid  out  1  to PRBS Valid, registered
pattern_correct  in  1  from PRBS checker
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when run completes
pass_cnt  out  CNT_WIDTH  entries that saw pattern_correct
fail_cnt  out  CNT_WIDTH  entries timed out or skipped

Behaviour:
- Reset (RST=0, async) clears all outputs, FIFO pointers and count, counters and the state, and forces IDLE. Reset mid-run drops prbs_valid immediately.
- FIFO behaviour:
  - A push while not full writes the entry and count+1 at the next edge.
  - A push while full is dropped and cfg_overflow pulses for 1 cycle.
  - Pushes are allowed in any state. An entry appended during a run is executed in that run.
  - Pop happens only in LOAD.
  - A push and a pop in the same cycle leave count unchanged. A push into a full FIFO in the same cycle as a pop is accepted.
- States:
  - IDLE: start=1 clears pass_cnt and fail_cnt, then goes to LOAD. start while busy is ignored.
  - LOAD:
    - FIFO empty: go to FIN.
    - Otherwise pop the head and register prbs_in/prbs_n.
    - Popped N=0: fail_cnt+1, stay in LOAD for the next entry. Valid is never driven for N=0.
    - Popped N≠0: go to DRIVE.
  - DRIVE: prbs_valid=1 for exactly VALID_CYCLES cycles, then go to WAIT with prbs_valid=0.
  - WAIT: up to TIMEOUT cycles.
- Pass/fail judging:
  - pattern_correct is sampled from the first DRIVE cycle through the end of WAIT.
  - The first sampled 1 latches a hit flag. A hit in DRIVE does not shorten DRIVE. A hit in WAIT ends WAIT on that edge.
  - Hit: pass_cnt+1. No hit by the end of WAIT: fail_cnt+1.
  - After judging, go to LOAD.
- FIN: done=1 for 1 cycle, then go to IDLE.
- prbs_in and prbs_n hold their last loaded value until the next LOAD pop. They are never cleared except by reset.
- Counters saturate at 2^CNT_WIDTH-1.
- abort:
  - Takes priority over everything except reset.
  - At the next edge: state=IDLE, prbs_valid=0, FIFO flushed, no done pulse, counters hold their values.
  - abort and start in the same IDLE cycle: abort wins.
- Latency: start edge to first prbs_valid=1 is 2 cycles (IDLE→LOAD→DRIVE).

Test Plan:
- Reset check: hold RST=0 mid-DRIVE -> prbs_valid, busy, pass_cnt and fail_cnt all read 0 asynchronously; state is IDLE after release.
- Single pass: push (0xABCD0402, N=2); start; checker model asserts pattern_correct 8 cycles after Valid rises -> prbs_in=0xABCD0402, prbs_n=2, prbs_valid high exactly 5 cycles, pass_cnt=1, fail_cnt=0, done pulse once.
- Timeout: push (0xABCD0102, N=2); pattern_correct held 0 -> WAIT lasts 64 cycles, fail_cnt=1, done pulses 2+5+64+1 cycles after start (±1 per the LOAD/FIN edges).
- Queue mix: push (0x11111111, 3), (0x22222222, 0), (0x33333333, 1); first passes, third times out -> Valid bursts only for entries 1 and 3, pass_cnt=1, fail_cnt=2.
- FIFO boundary: 5 pushes with DEPTH=4 -> cfg_full=1 after the 4th, cfg_overflow pulses on the 5th, run executes 4 entries. Push during run on the final WAIT -> entry is executed before done.
- Abort/start misuse: start with empty FIFO -> done 2 cycles later, counters 0. Abort during DRIVE with 2 queued -> prbs_valid=0 next cycle, FIFO empty, no done. Start while busy -> ignored.
